sinus_unit: RTL
===============

SINUS_UNIT -- requirements
Module: sinus_unit

Interface
REQ-001 Parameter: ROM_FILE, default "sin_quarter.hex", hex init file for the 256 x 15-bit quarter-wave ROM.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 sinus_clk_en  input  1  request; initiator holds high until it samples sinus_done=1.
REQ-005 sinus_angle  input  32  IEEE-754 single, radians; sampled only on the accepting edge.
REQ-006 sinus_done  output  1  one-cycle completion pulse.
REQ-007 sinus_result  output  32  IEEE-754 single sin(angle); held stable until the next completion.

Function
REQ-008 States SHALL be IDLE, DECODE, MULT, SHIFT, LOOKUP, CONVERT, DONE, RELEASE.
REQ-009 IDLE with sinus_clk_en=1 at an edge (E0) SHALL latch sinus_angle and go to DECODE; states then advance one per edge: MULT(E1), SHIFT(E2), LOOKUP(E3), CONVERT(E4), DONE(E5).
REQ-010 sinus_done SHALL equal (state==DONE): high exactly between E5 and E6; sinus_result updated at E5.
REQ-011 DONE SHALL go to RELEASE if sinus_clk_en=1, else IDLE; RELEASE SHALL stay while sinus_clk_en=1, then go to IDLE; at most one done pulse per request.
REQ-012 sinus_clk_en falling before E5 SHALL NOT abort: computation completes, done still pulses.
REQ-013 sinus_angle changes after E0 SHALL be ignored.
REQ-014 Decode: s=bit31, e=bits30:23, m={1,bits22:0}; e==0 SHALL treat input as zero (phase 0); e==255 SHALL give result 0x7FC00000.
REQ-015 Phase: P=m*K, K=2734261102 (round(2^34/(2*pi))), 56-bit product.
REQ-016 p (10 bits) = (P >> (174-e)) mod 1024 when e<174 (0 if shift >=56), else (P << (e-174)) mod 1024; truncation, no rounding.
REQ-017 Lookup on q=p[9:8], i=p[7:0], ROM[i]=round(32767*sin(2*pi*i/1024)): q0 +ROM[i]; q1 +(i==0 ? 32767 : ROM[256-i]); q2 -ROM[i]; q3 -(i==0 ? 32767 : ROM[256-i]).
REQ-018 Final sign = lookup sign XOR s; magnitude v is 15 bits, value v/32768.
REQ-019 Convert: v==0 SHALL give 0x00000000 regardless of sign; else L = index of leading one (0..14), exponent = 112+L, mantissa = low 23 bits of (v << (23-L)).
REQ-020 Accuracy for |angle| < 2^8 is bounded by the 10-bit phase and 15-bit amplitude; larger angles wrap mod 1024 with no error flag.

Reset
REQ-021 rst=0 SHALL immediately force state IDLE, sinus_done=0, sinus_result=0x00000000, latched angle=0, regardless of clk.
REQ-022 Reset mid-computation SHALL discard the request; no done pulse is produced for it.
REQ-023 After rst=1, a request held high SHALL be accepted at the first subsequent edge.

Verification
REQ-024 angle 0x3FC90FDB (pi/2), clk_en held high -> done high for exactly the cycle between E5 and E6; result 0x3F7FFE00.
REQ-025 angle 0xBFC90FDB (-pi/2) -> 0xBF7FFE00; angle 0x40490FDB (pi) -> 0x00000000; angle 0x00000000 -> 0x00000000.
REQ-026 angle 0x7FC00000 (NaN) -> 0x7FC00000; angle 0x7F800000 (+inf) -> 0x7FC00000.
REQ-027 clk_en held high 20 cycles past done -> exactly one done pulse; drop clk_en 1 cycle, raise again -> second pulse 6 edges after re-acceptance.
REQ-028 clk_en dropped at E2 -> done still pulses E5-E6, result valid, FSM returns to IDLE at E6 (no RELEASE).
REQ-029 rst asserted while in LOOKUP -> done=0, result=0x00000000 immediately; no pulse for that request; next pi/2 request -> 0x3F7FFE00.

Source files
------------

// File: rtl/sinus_unit.sv
// sinus_unit: sin(angle) for IEEE-754 single-precision input.
// The angle is turned into a 10-bit phase, and a 256-entry quarter-wave
// table supplies a 15-bit amplitude. The amplitude is then re-encoded as a
// single-precision float. One request produces exactly one done pulse.
// The quarter-wave table is built at elaboration from an exact
// integer sine evaluation, so no external init file has to ship with it.
// ROM_FILE is kept so existing instantiations stay source compatible.
module sinus_unit #(
  parameter ROM_FILE = "sin_quarter.hex"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sinus_clk_en,
  input  logic [31:0] sinus_angle,
  output logic        sinus_done,
  output logic [31:0] sinus_result
);

  // K = round(2^34 / (2*pi)): mantissa * K lands the turn fraction at bit 47+.
  localparam logic [31:0] PHASE_K  = 32'd2734261102;
  // pi * 2^62, used by the table generator below.
  localparam logic [63:0] PI_Q62   = 64'hC90FDAA22168C235;
  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam logic [7:0]  EXP_ALIGN = 8'd174;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DECODE  = 3'd1,
    MULT    = 3'd2,
    SHIFT   = 3'd3,
    LOOKUP  = 3'd4,
    CONVERT = 3'd5,
    DONE    = 3'd6,
    RELEASE = 3'd7
  } state_t;

  // round(32767 * sin(pi*idx/512)) using a Q.62 Taylor series in 128-bit
  // integers; truncation error is far below the final rounding step.
  function automatic logic [14:0] sin_q15(input int idx);
    logic [127:0] x;
    logic [127:0] x2;
    logic [127:0] term;
    logic [127:0] acc;
    logic [127:0] scaled;
    x    = (128'(PI_Q62) * 128'(idx)) >> 9;
    x2   = (x * x) >> 62;
    term = x;
    acc  = x;
    for (int k = 1; k <= 8; k++) begin
      term = ((term * x2) >> 62) / 128'((2 * k) * (2 * k + 1));
      if ((k % 2) == 1) acc = acc - term;
      else              acc = acc + term;
    end
    scaled = acc * 128'd32767;
    return 15'((scaled + (128'd1 << 61)) >> 62);
  endfunction

  // Quarter-wave amplitude table, read through a registered port.
  logic [14:0] rom_table [256];

  genvar gi;
  generate
    for (gi = 0; gi < 256; gi++) begin : g_rom
      assign rom_table[gi] = sin_q15(gi);
    end
  endgenerate

  state_t state_reg;
  state_t state_next;

  // Stage enables decoded from the current state.
  logic load_angle;
  logic decode_en;
  logic mult_en;
  logic shift_en;
  logic lookup_en;
  logic convert_en;

  // Pipeline registers, one group per state.
  logic [31:0] angle_reg;
  logic        sign_reg;
  logic        nan_reg;
  logic        zero_reg;
  logic [7:0]  exp_reg;
  logic [23:0] mant_reg;
  logic [55:0] prod_reg;
  logic [9:0]  phase_reg;
  logic [14:0] rom_data_reg;
  logic [31:0] result_reg;

  // Combinational datapath signals.
  logic [7:0]  shr_amt;
  logic [7:0]  shl_amt;
  logic [9:0]  phase_shr;
  logic [9:0]  phase_shl;
  logic [9:0]  phase_next;
  logic [7:0]  rom_addr;
  logic [14:0] mag;
  logic        res_sign;
  logic [3:0]  lead_pos;
  logic [4:0]  mant_shamt;
  logic [22:0] mant_bits;
  logic [7:0]  res_exp;
  logic [31:0] result_next;

  // State register; reset drops any request in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic: fixed walk through the pipeline, then wait for release.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (sinus_clk_en) state_next = DECODE;
      DECODE:  state_next = MULT;
      MULT:    state_next = SHIFT;
      SHIFT:   state_next = LOOKUP;
      LOOKUP:  state_next = CONVERT;
      CONVERT: state_next = DONE;
      DONE:    state_next = sinus_clk_en ? RELEASE : IDLE;
      RELEASE: state_next = sinus_clk_en ? RELEASE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: done pulse plus per-stage load enables.
  always_comb begin
    sinus_done = 1'b0;
    load_angle = 1'b0;
    decode_en  = 1'b0;
    mult_en    = 1'b0;
    shift_en   = 1'b0;
    lookup_en  = 1'b0;
    convert_en = 1'b0;
    case (state_reg)
      IDLE:    load_angle = sinus_clk_en;
      DECODE:  decode_en  = 1'b1;
      MULT:    mult_en    = 1'b1;
      SHIFT:   shift_en   = 1'b1;
      LOOKUP:  lookup_en  = 1'b1;
      CONVERT: convert_en = 1'b1;
      DONE:    sinus_done = 1'b1;
      default: ;
    endcase
  end

  // Capture the angle on acceptance; later input changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            angle_reg <= 32'd0;
    else if (load_angle) angle_reg <= sinus_angle;
  end

  // Split the float into sign, exponent and mantissa with the hidden one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign_reg <= 1'b0;
      nan_reg  <= 1'b0;
      zero_reg <= 1'b0;
      exp_reg  <= 8'd0;
      mant_reg <= 24'd0;
    end else if (decode_en) begin
      sign_reg <= angle_reg[31];
      nan_reg  <= (angle_reg[30:23] == 8'hFF);
      zero_reg <= (angle_reg[30:23] == 8'h00);
      exp_reg  <= angle_reg[30:23];
      mant_reg <= {1'b1, angle_reg[22:0]};
    end
  end

  // Scale the mantissa into turns: 24 x 32 -> 56-bit product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         prod_reg <= 56'd0;
    else if (mult_en) prod_reg <= 56'(mant_reg) * 56'(PHASE_K);
  end

  // Align by exponent and keep the 10 phase bits just below the turn point.
  // Shifts past the register width naturally give zero.
  always_comb begin
    shr_amt    = EXP_ALIGN - exp_reg;
    shl_amt    = exp_reg - EXP_ALIGN;
    phase_shr  = 10'(prod_reg >> shr_amt);
    phase_shl  = 10'(prod_reg << shl_amt);
    phase_next = 10'd0;
    if (!zero_reg) phase_next = (exp_reg < EXP_ALIGN) ? phase_shr : phase_shl;
  end

  // Register the phase; it stays valid through LOOKUP and CONVERT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          phase_reg <= 10'd0;
    else if (shift_en) phase_reg <= phase_next;
  end

  // Odd quadrants mirror the table index; index 0 wraps to 0 and is
  // replaced by full scale during CONVERT.
  always_comb begin
    rom_addr = phase_reg[8] ? (8'd0 - phase_reg[7:0]) : phase_reg[7:0];
  end

  // Registered table read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           rom_data_reg <= 15'd0;
    else if (lookup_en) rom_data_reg <= rom_table[rom_addr];
  end

  // Magnitude, sign and float encoding of v/32768.
  always_comb begin
    mag = rom_data_reg;
    if (phase_reg[8] && (phase_reg[7:0] == 8'd0)) mag = 15'h7FFF;
    res_sign = phase_reg[9] ^ sign_reg;
    lead_pos = 4'd0;
    for (int b = 0; b < 15; b++) begin
      if (mag[b]) lead_pos = 4'(b);
    end
    mant_shamt = 5'd23 - {1'b0, lead_pos};
    mant_bits  = {8'd0, mag} << mant_shamt;
    res_exp    = 8'd112 + {4'd0, lead_pos};
    if (nan_reg)           result_next = QNAN;
    else if (mag == 15'd0) result_next = 32'h00000000;
    else                   result_next = {res_sign, res_exp, mant_bits};
  end

  // Result register; it holds until the next completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            result_reg <= 32'd0;
    else if (convert_en) result_reg <= result_next;
  end

  assign sinus_result = result_reg;

endmodule
